// File: rtl/mod_check_pkg.sv
// rtl/mod_check_pkg.sv - shared types and defaults for the divisibility-check scheduler
package mod_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int DEFAULT_WORD_W  = 8;
    localparam int DEFAULT_DIVISOR = 5;

    function automatic int res_w(input int divisor);
        return $clog2(divisor);
    endfunction

endpackage

// File: rtl/mod_residue_engine.sv
// rtl/mod_residue_engine.sv - bit-serial MSB-first mod-DIVISOR residue engine
module mod_residue_engine
    import mod_check_pkg::*;
#(
    parameter int WORD_W  = DEFAULT_WORD_W,
    parameter int DIVISOR = DEFAULT_DIVISOR,
    parameter int RES_W   = res_w(DIVISOR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic              step,
    output logic [RES_W-1:0]  residue,
    output logic              last_bit
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WORD_W);
    localparam logic [RES_W:0]   DIV_L    = (RES_W + 1)'(DIVISOR);

    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  count;
    logic [RES_W:0]    doubled;
    logic [RES_W:0]    reduced;

    // residue < DIVISOR, so 2*residue+bit < 2*DIVISOR and one subtract suffices
    assign doubled  = {residue, shreg[WORD_W-1]};
    assign reduced  = doubled - DIV_L;
    assign last_bit = (count == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg   <= '0;
            residue <= '0;
            count   <= '0;
        end else if (load) begin
            shreg   <= word;
            residue <= '0;
            count   <= CNT_INIT;
        end else if (step) begin
            residue <= (doubled >= DIV_L) ? reduced[RES_W-1:0] : doubled[RES_W-1:0];
            shreg   <= shreg << 1;
            count   <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/mod_check_scheduler.sv
// rtl/mod_check_scheduler.sv - two-requester round-robin front end and FSM for the residue engine
module mod_check_scheduler
    import mod_check_pkg::*;
#(
    parameter int  WORD_W  = DEFAULT_WORD_W,
    parameter int  DIVISOR = DEFAULT_DIVISOR,
    localparam int RES_W   = res_w(DIVISOR)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    input  logic [2*WORD_W-1:0] req_data,
    output logic [1:0]          req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [RES_W-1:0]    rsp_rem,
    output logic                rsp_div,
    output logic                busy
);

    state_t            state;
    logic              rr_last;
    logic              grant;
    logic              load;
    logic              step;
    logic              last_bit;
    logic [RES_W-1:0]  residue;
    logic [WORD_W-1:0] word;

    // requester 1 wins when alone, or when both ask and 0 was served last
    always_comb begin
        grant     = req_valid[1] & (~req_valid[0] | ~rr_last);
        load      = (state == IDLE) && (|req_valid);
        step      = (state == SHIFT);
        req_ready = load ? {grant, ~grant} : 2'b00;
        word      = grant ? req_data[WORD_W +: WORD_W] : req_data[0 +: WORD_W];
    end

    mod_residue_engine #(
        .WORD_W  (WORD_W),
        .DIVISOR (DIVISOR),
        .RES_W   (RES_W)
    ) u_engine (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .word     (word),
        .step     (step),
        .residue  (residue),
        .last_bit (last_bit)
    );

    // the engine's residue register is frozen in RESP, so it serves as the result register
    assign rsp_rem = rsp_valid ? residue : '0;
    assign rsp_div = rsp_valid && (residue == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        rsp_id <= grant;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_last   <= rsp_id;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_check_scheduler.sv
// tb/tb_mod_check_scheduler.sv - directed self-checking bench for mod_check_scheduler
module tb_mod_check_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_div, busy;
    logic [2:0]  rsp_rem;

    logic [1:0]  req_valid_b;
    logic [23:0] req_data_b;
    logic [1:0]  req_ready_b;
    logic        rsp_valid_b, rsp_ready_b, rsp_id_b, rsp_div_b, busy_b;
    logic [1:0]  rsp_rem_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_check_scheduler dut (
        .clk (clk), .rst_n (rst_n), .req_valid (req_valid), .req_data (req_data),
        .req_ready (req_ready), .rsp_valid (rsp_valid), .rsp_ready (rsp_ready),
        .rsp_id (rsp_id), .rsp_rem (rsp_rem), .rsp_div (rsp_div), .busy (busy)
    );

    mod_check_scheduler #(.WORD_W (12), .DIVISOR (3)) dut_b (
        .clk (clk), .rst_n (rst_n), .req_valid (req_valid_b), .req_data (req_data_b),
        .req_ready (req_ready_b), .rsp_valid (rsp_valid_b), .rsp_ready (rsp_ready_b),
        .rsp_id (rsp_id_b), .rsp_rem (rsp_rem_b), .rsp_div (rsp_div_b), .busy (busy_b)
    );

    typedef struct {
        int         id;
        logic [7:0] data;
        logic [2:0] rem;
        logic       div;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1)
            check("ready_onehot", req_ready == 2'b11, 0);
    end

    task automatic serve(input int r, input logic [7:0] d, input logic [2:0] erem,
                         input logic ediv, input string tag);
        int lat;
        bit seen;
        @(negedge clk);
        req_data = '0;
        req_data[r*8 +: 8] = d;
        req_valid = 2'b01 << r;
        #1;
        check({tag, " ready"}, req_ready, 2'b01 << r);
        @(posedge clk);
        lat  = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            if (lat == 0) begin
                req_valid = 2'b00;
                check({tag, " busy"}, busy, 1);
            end
            if (rsp_valid) begin
                seen = 1;
                check({tag, " rem"}, rsp_rem, erem);
                check({tag, " div"}, rsp_div, ediv);
                check({tag, " id"}, rsp_id, r);
            end
            @(posedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, 9);
        @(negedge clk);
        check({tag, " valid_drop"}, rsp_valid, 0);
    endtask

    initial begin
        int w;
        int lat;
        int spurious;

        vecs[0] = '{0, 8'd35,  3'd0, 1'b1};
        vecs[1] = '{1, 8'd23,  3'd3, 1'b0};
        vecs[2] = '{1, 8'd254, 3'd4, 1'b0};
        vecs[3] = '{1, 8'd0,   3'd0, 1'b1};
        vecs[4] = '{0, 8'd7,   3'd2, 1'b0};
        vecs[5] = '{0, 8'd255, 3'd0, 1'b1};
        vecs[6] = '{1, 8'd1,   3'd1, 1'b0};
        vecs[7] = '{0, 8'd128, 3'd3, 1'b0};

        rst_n = 1'b0;
        req_valid = '0; req_data = '0; rsp_ready = 1'b0;
        req_valid_b = '0; req_data_b = '0; rsp_ready_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst req_ready", req_ready, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst rsp_id", rsp_id, 0);
        check("rst rsp_rem", rsp_rem, 0);
        check("rst rsp_div", rsp_div, 0);
        check("rst busy", busy, 0);
        check("rst_b busy", busy_b, 0);
        check("rst_b rsp_valid", rsp_valid_b, 0);
        rst_n = 1'b1;

        // both requesters held valid straight out of reset
        @(negedge clk);
        req_data = {8'd11, 8'd10};
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            w = 0;
            #1;
            while (req_ready == 2'b00 && w < 30) begin @(negedge clk); #1; w++; end
            check("arb grant", req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
            w = 0;
            while (!rsp_valid && w < 30) begin @(negedge clk); #1; w++; end
            check("arb id", rsp_id, g % 2);
            check("arb rem", rsp_rem, (g % 2 == 0) ? 0 : 1);
            check("arb div", rsp_div, (g % 2 == 0) ? 1 : 0);
            @(negedge clk);
        end
        req_valid = 2'b00;

        for (int i = 0; i < 8; i++)
            serve(vecs[i].id, vecs[i].data, vecs[i].rem, vecs[i].div, $sformatf("vec%0d", i));

        // held response under backpressure while the other requester waits
        @(negedge clk);
        rsp_ready = 1'b0;
        req_data = {8'd3, 8'd7};
        req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b10;
        w = 0;
        while (!rsp_valid && w < 30) begin @(negedge clk); w++; end
        for (int c = 0; c < 5; c++) begin
            check("bp valid", rsp_valid, 1);
            check("bp rem", rsp_rem, 2);
            check("bp id", rsp_id, 0);
            check("bp req_ready", req_ready, 0);
            check("bp busy", busy, 1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp released", rsp_valid, 0);
        check("bp idle grant", req_ready, 2'b10);
        req_valid = 2'b00;

        // reset during the 4th shift cycle of 99
        @(negedge clk);
        req_data = {8'd0, 8'd99};
        req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        check("midrst busy_before", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst busy", busy, 0);
        check("midrst rsp_valid", rsp_valid, 0);
        rst_n = 1'b1;
        spurious = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) spurious++;
        end
        check("midrst no_response", spurious, 0);
        serve(0, 8'd99, 3'd4, 1'b0, "after_rst");

        // WORD_W=12, DIVISOR=3 variant
        @(negedge clk);
        rsp_ready_b = 1'b1;
        req_data_b = {12'd0, 12'd200};
        req_valid_b = 2'b01;
        #1;
        check("var ready", req_ready_b, 2'b01);
        @(posedge clk);
        lat = 0;
        w = 0;
        while (w == 0 && lat < 40) begin
            @(negedge clk);
            req_valid_b = 2'b00;
            if (rsp_valid_b) begin
                w = 1;
                check("var rem", rsp_rem_b, 2);
                check("var div", rsp_div_b, 0);
                check("var id", rsp_id_b, 0);
            end
            @(posedge clk);
            lat++;
        end
        check("var latency", lat, 13);
        @(negedge clk);
        check("var valid_drop", rsp_valid_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
